ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL be the data word width in bits.
REQ-002 Parameter ENTRIES, default 100, SHALL be the RAM depth in words; ADDR_W = $clog2(ENTRIES) SHALL be derived as a localparam, not overridable.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Req0 / Req1  input  1 each  SHALL be the access requests from requester 0 (CPU data port) and requester 1 (loader/DMA).
REQ-006 WE0 / WE1  input  1 each  SHALL be the write enables: 1 = write, 0 = read.
REQ-007 A0 / A1  input  ADDR_W each  SHALL be the word addresses.
REQ-008 WD0 / WD1  input  WORD_WIDTH each  SHALL be the write data.
REQ-009 Gnt0 / Gnt1  output  1 each  SHALL be the combinational grant, one cycle wide per accepted access.
REQ-010 Rvalid0 / Rvalid1  output  1 each  SHALL be the registered read-data-valid flags.
REQ-011 RD0 / RD1  output  WORD_WIDTH each  SHALL be the registered read-data returns.
REQ-012 Err  output  1  SHALL be a registered flag marking an out-of-range access.
REQ-013 Ram_A  output  ADDR_W;  Ram_WD  output  WORD_WIDTH;  Ram_WE  output  1  SHALL drive the RAM.
REQ-014 Ram_RD  input  WORD_WIDTH  SHALL be the combinational RAM read data.

Function
REQ-015 At most one access SHALL be granted per cycle; Gnt0 and Gnt1 SHALL never both be 1.
REQ-016 Only one requester active: it SHALL be granted in the same cycle.
REQ-017 Both active: the requester indicated by the round-robin pointer PRI SHALL be granted; PRI SHALL then point to the other requester.
REQ-018 PRI SHALL change only on a granted cycle; cycles with no grant leave PRI unchanged.
REQ-019 Handshake: a requester SHALL hold Req, WE, A and WD stable until it samples its Gnt high; a request deasserted before grant is dropped with no side effect.
REQ-020 Ram_A, Ram_WD and Ram_WE SHALL be muxed from the granted requester; with no grant, Ram_WE = 0 and Ram_A/Ram_WD = 0.
REQ-021 Granted read: Ram_RD SHALL be captured into RDn at the grant edge; Rvalidn SHALL be 1 for exactly the following cycle (latency 1).
REQ-022 Granted write: Ram_WE = 1 during the grant cycle; no Rvalid pulse follows.
REQ-023 RDn SHALL hold its last value until the next granted read from the same requester.
REQ-024 Out-of-range access (A >= ENTRIES): the access SHALL still be granted and consume its slot, Ram_WE forced to 0, RDn loaded with 0, Rvalidn pulsed for a read, and Err = 1 for the following cycle.
REQ-025 Back-to-back: a requester holding Req over consecutive cycles SHALL alternate with a competing requester, never starving it for more than 1 cycle.
REQ-026 Pipelining: a new grant SHALL be permitted in the cycle that an Rvalid from a previous grant is high, giving full throughput of 1 access per cycle.

Reset
REQ-027 While Rst = 1 at a rising edge: PRI = 0 (requester 0 preferred), Rvalid0 = Rvalid1 = 0, RD0 = RD1 = 0, Err = 0.
REQ-028 While Rst = 1: Gnt0 = Gnt1 = 0 and Ram_WE = 0 regardless of Req, so no write reaches the RAM.
REQ-029 A reset asserted in the cycle after a read grant SHALL suppress that Rvalid pulse.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the requester index constants (REQ_CPU = 0, REQ_DMA = 1) and the default WORD_WIDTH/ENTRIES values.
REQ-031 Sub-module rr_pick2 SHALL contain the two-way round-robin grant logic plus the PRI register; all muxing and response registers stay in ram_arbiter.
REQ-032 The bench SHALL instantiate ram_arbiter with the existing Ram (WORD_WIDTH = 32, ENTRIES = 100) on Ram_A/Ram_WD/Ram_WE/Ram_RD.

Verification
REQ-033 Reset: Rst = 1 for 2 cycles with Req0 = Req1 = 1, WE = 1 -> Gnt = 0, Ram_WE = 0, all outputs 0.
REQ-034 Solo write then read: Req1 write A = 1, WD = 'h4; next cycle Req1 read A = 1 -> Gnt1 in both cycles, RD1 = 'h4, Rvalid1 = 1 one cycle after the read grant.
REQ-035 Contention: Req0 and Req1 held for 4 cycles, reads at A = 0 and A = 2 (preloaded 'h2 and 'h6) -> grants in order 0, 1, 0, 1; RD0 = 'h2, RD1 = 'h6.
REQ-036 Out of range: Req0 write A = 100, WD = 'hFF, then read A = 100 -> Ram_WE = 0, Err pulses after each access, RD0 = 0 with Rvalid0 = 1.
REQ-037 Reset mid-operation: Req0 read granted, Rst = 1 on the next edge -> Rvalid0 stays 0, PRI returns to 0, and the next contention grants requester 0 first.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: requester indices and defaults.
package ram_arb_pkg;

   localparam int REQ_CPU = 0;
   localparam int REQ_DMA = 1;

   localparam int unsigned DEF_WORD_WIDTH = 32;
   localparam int unsigned DEF_ENTRIES    = 100;

   typedef enum logic {
      PRI_CPU = 1'b0,
      PRI_DMA = 1'b1
   } pri_e;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker; owns the priority pointer.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   pri_e r_pri;

   // Grant the sole requester, or the preferred one under contention; none in reset.
   always_comb begin
      o_gnt = '0;
      if (!Rst) begin
         if (i_req[REQ_CPU] && (!i_req[REQ_DMA] || r_pri == PRI_CPU))
            o_gnt[REQ_CPU] = 1'b1;
         else if (i_req[REQ_DMA])
            o_gnt[REQ_DMA] = 1'b1;
      end
   end

   // After any grant, prefer the other requester next; idle cycles hold the pointer.
   always_ff @(posedge Clk) begin
      if (Rst)
         r_pri <= PRI_CPU;
      else if (o_gnt[REQ_CPU])
         r_pri <= PRI_DMA;
      else if (o_gnt[REQ_DMA])
         r_pri <= PRI_CPU;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port and a DMA port onto one single-ported RAM with
// combinational read data; read returns are registered with latency 1.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
   parameter  int unsigned ENTRIES    = DEF_ENTRIES,
   localparam int unsigned ADDR_W     = $clog2(ENTRIES)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Req0,
   input  logic                  Req1,
   input  logic                  WE0,
   input  logic                  WE1,
   input  logic [ADDR_W-1:0]     A0,
   input  logic [ADDR_W-1:0]     A1,
   input  logic [WORD_WIDTH-1:0] WD0,
   input  logic [WORD_WIDTH-1:0] WD1,
   output logic                  Gnt0,
   output logic                  Gnt1,
   output logic                  Rvalid0,
   output logic                  Rvalid1,
   output logic [WORD_WIDTH-1:0] RD0,
   output logic [WORD_WIDTH-1:0] RD1,
   output logic                  Err,
   output logic [ADDR_W-1:0]     Ram_A,
   output logic [WORD_WIDTH-1:0] Ram_WD,
   output logic                  Ram_WE,
   input  logic [WORD_WIDTH-1:0] Ram_RD
);

   localparam logic [ADDR_W:0] LIMIT = ENTRIES[ADDR_W:0];

   logic [1:0]            w_gnt;
   logic                  w_oor0;
   logic                  w_oor1;
   logic                  w_rd0;
   logic                  w_rd1;
   logic                  r_rvalid0;
   logic                  r_rvalid1;
   logic [WORD_WIDTH-1:0] r_rd0;
   logic [WORD_WIDTH-1:0] r_rd1;
   logic                  r_err;

   rr_pick2 u_pick (
      .Clk   (Clk),
      .Rst   (Rst),
      .i_req ({Req1, Req0}),
      .o_gnt (w_gnt)
   );

   assign Gnt0   = w_gnt[REQ_CPU];
   assign Gnt1   = w_gnt[REQ_DMA];
   assign w_oor0 = ({1'b0, A0} >= LIMIT);
   assign w_oor1 = ({1'b0, A1} >= LIMIT);
   assign w_rd0  = Gnt0 && !WE0;
   assign w_rd1  = Gnt1 && !WE1;

   // Steer the granted requester onto the RAM; out-of-range writes never reach it.
   always_comb begin
      Ram_A  = '0;
      Ram_WD = '0;
      Ram_WE = 1'b0;
      if (Gnt0) begin
         Ram_A  = A0;
         Ram_WD = WD0;
         Ram_WE = WE0 && !w_oor0;
      end else if (Gnt1) begin
         Ram_A  = A1;
         Ram_WD = WD1;
         Ram_WE = WE1 && !w_oor1;
      end
   end

   // Capture read data and flag out-of-range accesses at the grant edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rd0     <= '0;
         r_rd1     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_rvalid0 <= w_rd0;
         r_rvalid1 <= w_rd1;
         if (w_rd0)
            r_rd0 <= w_oor0 ? '0 : Ram_RD;
         if (w_rd1)
            r_rd1 <= w_oor1 ? '0 : Ram_RD;
         r_err <= (Gnt0 && w_oor0) || (Gnt1 && w_oor1);
      end
   end

   // Reset raised in the cycle after a read grant must cancel the pending pulse,
   // so the registered valid is also gated by Rst.
   assign Rvalid0 = r_rvalid0 && !Rst;
   assign Rvalid1 = r_rvalid1 && !Rst;
   assign RD0     = r_rd0;
   assign RD1     = r_rd1;
   assign Err     = r_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and reference model.
module tb_ram_arbiter;

   logic        Clk, Rst, Req0, Req1, WE0, WE1;
   logic [6:0]  A0, A1, Ram_A;
   logic [31:0] WD0, WD1, RD0, RD1, Ram_WD, Ram_RD;
   logic        Gnt0, Gnt1, Rvalid0, Rvalid1, Err, Ram_WE;

   int errors = 0;
   int checks = 0;

   // Behavioural RAM driven by the arbiter
   logic [31:0] ram_mem [0:99];
   assign Ram_RD = (int'(Ram_A) < 100) ? ram_mem[Ram_A] : 32'h0;
   always @(posedge Clk) if (Ram_WE && int'(Ram_A) < 100) ram_mem[Ram_A] <= Ram_WD;

   ram_arbiter #(.WORD_WIDTH(32), .ENTRIES(100)) dut (
      .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .WE0(WE0), .WE1(WE1),
      .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1), .Gnt0(Gnt0), .Gnt1(Gnt1),
      .Rvalid0(Rvalid0), .Rvalid1(Rvalid1), .RD0(RD0), .RD1(RD1), .Err(Err),
      .Ram_A(Ram_A), .Ram_WD(Ram_WD), .Ram_WE(Ram_WE), .Ram_RD(Ram_RD)
   );

   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   // Reference model: priority bit, last-response state and memory image
   bit          m_pri, m_rv0, m_rv1, m_err;
   logic [31:0] m_rd0, m_rd1;
   logic [31:0] m_mem [0:99];
   bit          e_g0, e_g1, e_we;
   logic [6:0]  e_a;
   logic [31:0] e_wd;

   task automatic model_comb();
      e_g0 = 0; e_g1 = 0;
      if (!Rst) begin
         if (Req0 && Req1) begin
            if (!m_pri) e_g0 = 1; else e_g1 = 1;
         end else if (Req0) e_g0 = 1;
         else if (Req1) e_g1 = 1;
      end
      e_a = 0; e_wd = 0; e_we = 0;
      if (e_g0) begin e_a = A0; e_wd = WD0; e_we = WE0 && int'(A0) < 100; end
      if (e_g1) begin e_a = A1; e_wd = WD1; e_we = WE1 && int'(A1) < 100; end
   endtask

   task automatic model_edge();
      model_comb();
      if (Rst) begin
         m_pri = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0; m_err = 0;
      end else begin
         m_err = (e_g0 && int'(A0) >= 100) || (e_g1 && int'(A1) >= 100);
         m_rv0 = e_g0 && !WE0;
         m_rv1 = e_g1 && !WE1;
         if (m_rv0) m_rd0 = (int'(A0) < 100) ? m_mem[A0] : 32'h0;
         if (m_rv1) m_rd1 = (int'(A1) < 100) ? m_mem[A1] : 32'h0;
         if (e_we) m_mem[e_a] = e_wd;
         if (e_g0) m_pri = 1; else if (e_g1) m_pri = 0;
      end
   endtask

   // Sample point: falling edge; inputs change 1 time unit after the rising edge
   task automatic half();
      @(negedge Clk);
      model_comb();
   endtask

   task automatic edge_step();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   function automatic logic [6:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 7'($urandom_range(100, 127));
      return 7'($urandom_range(0, 99));
   endfunction

   task automatic test_reset();
      Rst = 1; Req0 = 1; Req1 = 1; WE0 = 1; WE1 = 1; A0 = 5; A1 = 6; WD0 = 32'hAAAA; WD1 = 32'hBBBB;
      half();
      checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0_c1 got=%b exp=0", Gnt0); end
      checks++; if (Gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1_c1 got=%b exp=0", Gnt1); end
      checks++; if (Ram_WE !== 1'b0) begin errors++; $display("FAIL rst_ramwe_c1 got=%b exp=0", Ram_WE); end
      edge_step();
      half();
      checks++; if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt_c2 got=%b%b exp=00", Gnt1, Gnt0); end
      checks++; if (Ram_WE !== 1'b0) begin errors++; $display("FAIL rst_ramwe_c2 got=%b exp=0", Ram_WE); end
      checks++; if (Rvalid0 !== 1'b0 || Rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b%b exp=00", Rvalid1, Rvalid0); end
      checks++; if (RD0 !== 32'h0 || RD1 !== 32'h0) begin errors++; $display("FAIL rst_rd got=%h/%h exp=0/0", RD0, RD1); end
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", Err); end
      edge_step();
      checks++; if (ram_mem[5] !== 32'h5 || ram_mem[6] !== 32'h6) begin errors++; $display("FAIL rst_nowrite got=%h/%h exp=5/6", ram_mem[5], ram_mem[6]); end
      Rst = 0; Req0 = 0; Req1 = 0;
   endtask

   task automatic test_solo();
      Req1 = 1; WE1 = 1; A1 = 1; WD1 = 32'h4;
      half();
      checks++; if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0) begin errors++; $display("FAIL solo_wr_gnt got=%b%b exp=10", Gnt1, Gnt0); end
      checks++; if (Ram_WE !== 1'b1 || Ram_A !== 7'd1 || Ram_WD !== 32'h4) begin errors++; $display("FAIL solo_wr_ram got=%b/%h/%h exp=1/01/4", Ram_WE, Ram_A, Ram_WD); end
      edge_step();
      WE1 = 0;
      half();
      checks++; if (Gnt1 !== 1'b1 || Ram_WE !== 1'b0) begin errors++; $display("FAIL solo_rd_gnt got=%b/%b exp=1/0", Gnt1, Ram_WE); end
      checks++; if (Rvalid1 !== 1'b0) begin errors++; $display("FAIL solo_wr_novalid got=%b exp=0", Rvalid1); end
      edge_step();
      Req1 = 0;
      half();
      checks++; if (Rvalid1 !== 1'b1 || RD1 !== 32'h4) begin errors++; $display("FAIL solo_rd_data got=%b/%h exp=1/4", Rvalid1, RD1); end
      edge_step();
      half();
      checks++; if (Rvalid1 !== 1'b0 || RD1 !== 32'h4) begin errors++; $display("FAIL solo_rd_hold got=%b/%h exp=0/4", Rvalid1, RD1); end
      edge_step();
   endtask

   task automatic test_contention();
      Req0 = 1; WE0 = 0; A0 = 0; Req1 = 1; WE1 = 0; A1 = 2;
      for (int i = 0; i < 4; i++) begin
         half();
         checks++; if (Gnt0 !== (i % 2 == 0) || Gnt1 !== (i % 2 == 1)) begin errors++; $display("FAIL cont_order[%0d] got=%b%b exp=%b%b", i, Gnt1, Gnt0, i % 2 == 1, i % 2 == 0); end
         if (i == 1) begin
            checks++; if (Rvalid0 !== 1'b1 || RD0 !== 32'h2) begin errors++; $display("FAIL cont_rd0 got=%b/%h exp=1/2", Rvalid0, RD0); end
         end
         if (i == 2) begin
            checks++; if (Rvalid1 !== 1'b1 || RD1 !== 32'h6) begin errors++; $display("FAIL cont_rd1 got=%b/%h exp=1/6", Rvalid1, RD1); end
         end
         edge_step();
      end
      Req0 = 0; Req1 = 0;
      half();
      checks++; if (Rvalid1 !== 1'b1 || RD1 !== 32'h6 || RD0 !== 32'h2) begin errors++; $display("FAIL cont_final got=%b/%h/%h exp=1/6/2", Rvalid1, RD1, RD0); end
      edge_step();
   endtask

   task automatic test_out_of_range();
      Req0 = 1; WE0 = 1; A0 = 7'd100; WD0 = 32'hFF;
      half();
      checks++; if (Gnt0 !== 1'b1 || Ram_WE !== 1'b0) begin errors++; $display("FAIL oor_wr got=%b/%b exp=1/0", Gnt0, Ram_WE); end
      edge_step();
      WE0 = 0;
      half();
      checks++; if (Err !== 1'b1 || Gnt0 !== 1'b1 || Rvalid0 !== 1'b0) begin errors++; $display("FAIL oor_wr_err got=%b/%b/%b exp=1/1/0", Err, Gnt0, Rvalid0); end
      edge_step();
      Req0 = 0;
      half();
      checks++; if (Err !== 1'b1 || Rvalid0 !== 1'b1 || RD0 !== 32'h0) begin errors++; $display("FAIL oor_rd got=%b/%b/%h exp=1/1/0", Err, Rvalid0, RD0); end
      edge_step();
      half();
      checks++; if (Err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%b exp=0", Err); end
      edge_step();
   endtask

   task automatic test_reset_mid();
      Req0 = 1; WE0 = 0; A0 = 0;
      half();
      checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_gnt got=%b exp=1", Gnt0); end
      edge_step();
      Req0 = 0; Rst = 1;
      half();
      checks++; if (Rvalid0 !== 1'b0) begin errors++; $display("FAIL rmid_suppress got=%b exp=0", Rvalid0); end
      edge_step();
      Rst = 0; Req0 = 1; WE0 = 0; A0 = 2; Req1 = 1; WE1 = 0; A1 = 0;
      half();
      checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin errors++; $display("FAIL rmid_pri got=%b%b exp=01", Gnt1, Gnt0); end
      checks++; if (RD0 !== 32'h0 || Rvalid0 !== 1'b0) begin errors++; $display("FAIL rmid_rd0 got=%h/%b exp=0/0", RD0, Rvalid0); end
      edge_step();
      Req0 = 0;
      half();
      checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL rmid_next got=%b exp=1", Gnt1); end
      edge_step();
      Req1 = 0;
   endtask

   task automatic test_random();
      int w0, w1;
      bit g0, g1;
      w0 = 0; w1 = 0;
      for (int n = 0; n < 400; n++) begin
         if (!Req0 && $urandom_range(0, 2) != 0) begin Req0 = 1; WE0 = 1'($urandom_range(0, 1)); A0 = rand_addr(); WD0 = $urandom; end
         if (!Req1 && $urandom_range(0, 2) != 0) begin Req1 = 1; WE1 = 1'($urandom_range(0, 1)); A1 = rand_addr(); WD1 = $urandom; end
         Rst = ($urandom_range(0, 39) == 0);
         half();
         checks++; if (Gnt0 !== e_g0 || Gnt1 !== e_g1) begin errors++; $display("FAIL rnd_gnt[%0d] got=%b%b exp=%b%b", n, Gnt1, Gnt0, e_g1, e_g0); end
         checks++; if (Ram_WE !== e_we || Ram_A !== e_a || Ram_WD !== e_wd) begin errors++; $display("FAIL rnd_ram[%0d] got=%b/%h/%h exp=%b/%h/%h", n, Ram_WE, Ram_A, Ram_WD, e_we, e_a, e_wd); end
         checks++; if (Rvalid0 !== (m_rv0 && !Rst) || Rvalid1 !== (m_rv1 && !Rst)) begin errors++; $display("FAIL rnd_rvalid[%0d] got=%b%b exp=%b%b", n, Rvalid1, Rvalid0, m_rv1 && !Rst, m_rv0 && !Rst); end
         checks++; if (RD0 !== m_rd0 || RD1 !== m_rd1) begin errors++; $display("FAIL rnd_rd[%0d] got=%h/%h exp=%h/%h", n, RD0, RD1, m_rd0, m_rd1); end
         checks++; if (Err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, Err, m_err); end
         checks++; if (Gnt0 === 1'b1 && Gnt1 === 1'b1) begin errors++; $display("FAIL rnd_onehot[%0d] got=11 exp=not both", n); end
         g0 = e_g0; g1 = e_g1;
         edge_step();
         if (Rst) begin w0 = 0; w1 = 0; end
         else begin
            if (g0) w0 = 0; else if (Req0) w0++;
            if (g1) w1 = 0; else if (Req1) w1++;
         end
         checks++; if (w0 > 1 || w1 > 1) begin errors++; $display("FAIL rnd_starve[%0d] got=%0d/%0d exp<=1", n, w0, w1); end
         if (g0) Req0 = 0;
         if (g1) Req1 = 0;
      end
      Rst = 0; Req0 = 0; Req1 = 0;
   endtask

   initial begin
      for (int i = 0; i < 100; i++) begin
         ram_mem[i] = 32'(i);
         m_mem[i]   = 32'(i);
      end
      ram_mem[0] = 32'h2; m_mem[0] = 32'h2;
      ram_mem[2] = 32'h6; m_mem[2] = 32'h6;
      m_pri = 0; m_rv0 = 0; m_rv1 = 0; m_err = 0; m_rd0 = 0; m_rd1 = 0;
      test_reset();
      test_solo();
      test_contention();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
